bcd_to_binary_converter: RTL and testbench

BCD_TO_BINARY_CONVERTER -- requirements
Module: bcd_to_binary_converter

---
 rtl/bcd_to_binary_converter.sv | 112 +++++++++++
 tb/tb_bcd_to_binary_converter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary_converter.sv
// Sequential 3-digit BCD to binary converter using reverse double-dabble:
// shift the work register right and subtract 3 from every BCD digit >= 8.
module bcd_to_binary_converter #(
  parameter int BINARY_DATA_SIZE = 10,
  parameter int BCD_DATA_SIZE    = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [BCD_DATA_SIZE-1:0]    bcd_data,
  input  logic                        start_conversion,
  output logic [BINARY_DATA_SIZE-1:0] binary_data,
  output logic                        conversion_complete,
  output logic                        busy,
  output logic                        digit_error
);

  localparam int         WORK_W    = BCD_DATA_SIZE + BINARY_DATA_SIZE;
  localparam logic [3:0] LAST_ITER = 4'(BINARY_DATA_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_r;
  logic [WORK_W-1:0]   work_r;
  logic [WORK_W-1:0]   shifted_s;
  logic [WORK_W-1:0]   work_next_s;
  logic [3:0]          count_r;

  function automatic logic digits_valid(input logic [11:0] bcd);
    return (bcd[11:8] <= 4'd9) && (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9);
  endfunction

  function automatic logic [3:0] adjust_digit(input logic [3:0] d);
    logic [3:0] r;
    if (d >= 4'd8) begin
      r = d - 4'd3;
    end else begin
      r = d;
    end
    return r;
  endfunction

  // One reverse double-dabble step: shift right, then correct each BCD digit
  always_comb begin
    shifted_s   = {1'b0, work_r[WORK_W-1:1]};
    work_next_s = {adjust_digit(shifted_s[WORK_W-1 -: 4]),
                   adjust_digit(shifted_s[WORK_W-5 -: 4]),
                   adjust_digit(shifted_s[WORK_W-9 -: 4]),
                   shifted_s[BINARY_DATA_SIZE-1:0]};
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r             <= IDLE;
      work_r              <= '0;
      count_r             <= 4'd0;
      binary_data         <= '0;
      conversion_complete <= 1'b0;
      busy                <= 1'b0;
      digit_error         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          conversion_complete <= 1'b0;
          if (start_conversion) begin
            busy <= 1'b1;
            if (digits_valid(bcd_data)) begin
              work_r      <= {bcd_data, {BINARY_DATA_SIZE{1'b0}}};
              count_r     <= 4'd0;
              digit_error <= 1'b0;
              state_r     <= SHIFT;
            end else begin
              // Bad digit: skip the shift phase and report immediately
              digit_error         <= 1'b1;
              binary_data         <= '0;
              conversion_complete <= 1'b1;
              state_r             <= DONE;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        SHIFT: begin
          work_r  <= work_next_s;
          count_r <= count_r + 4'd1;
          if (count_r == LAST_ITER) begin
            binary_data         <= work_next_s[BINARY_DATA_SIZE-1:0];
            conversion_complete <= 1'b1;
            state_r             <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          conversion_complete <= 1'b0;
          busy                <= 1'b0;
          state_r             <= IDLE;
        end
        default: begin
          conversion_complete <= 1'b0;
          busy                <= 1'b0;
          state_r             <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// Directed self-checking bench for bcd_to_binary_converter; inputs change
// and outputs are sampled on the falling clock edge.
module tb_bcd_to_binary_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] bcd_data;
  logic        start_conversion;
  logic [9:0]  binary_data;
  logic        conversion_complete;
  logic        busy;
  logic        digit_error;

  int checks = 0;
  int errors = 0;

  bcd_to_binary_converter dut (
    .clk                 (clk),
    .reset               (reset),
    .bcd_data            (bcd_data),
    .start_conversion    (start_conversion),
    .binary_data         (binary_data),
    .conversion_complete (conversion_complete),
    .busy                (busy),
    .digit_error         (digit_error)
  );

  always #5 clk = ~clk;

  // Called at a falling edge while IDLE; returns at the falling edge of the
  // first cycle after the start was sampled.
  task automatic pulse_start(input logic [11:0] v);
    bcd_data         = v;
    start_conversion = 1'b1;
    @(negedge clk);
    start_conversion = 1'b0;
  endtask

  // Measures cycles (counting the current one as 1) until conversion_complete,
  // bounded so a stuck design still reaches the summary.
  task automatic wait_complete(output int lat, output int busy_cnt);
    lat      = 1;
    busy_cnt = busy ? 1 : 0;
    while (!conversion_complete && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    start_conversion = 1'b1;
    bcd_data         = 12'h999;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++;
    if (conversion_complete !== 1'b0) begin errors++; $display("FAIL reset_complete got %0b want 0", conversion_complete); end
    checks++;
    if (binary_data !== 10'd0) begin errors++; $display("FAIL reset_binary got %0d want 0", binary_data); end
    checks++;
    if (digit_error !== 1'b0) begin errors++; $display("FAIL reset_digit_error got %0b want 0", digit_error); end
    start_conversion = 1'b0;
    reset            = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %0b want 0", busy); end
  endtask

  task automatic test_999();
    int lat, bc;
    pulse_start(12'h999);
    wait_complete(lat, bc);
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL c999_latency got %0d want 11", lat); end
    checks++;
    if (bc !== 11) begin errors++; $display("FAIL c999_busy_cycles got %0d want 11", bc); end
    checks++;
    if (binary_data !== 10'd999) begin errors++; $display("FAIL c999_result got %0d want 999", binary_data); end
    checks++;
    if (digit_error !== 1'b0) begin errors++; $display("FAIL c999_digit_error got %0b want 0", digit_error); end
    @(negedge clk);
    checks++;
    if (conversion_complete !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL c999_one_pulse got complete=%0b busy=%0b want 0 0", conversion_complete, busy);
    end
    checks++;
    if (binary_data !== 10'd999) begin errors++; $display("FAIL c999_hold got %0d want 999", binary_data); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] vin [3] = '{12'h000, 12'h255, 12'h100};
    logic [9:0]  vexp [3] = '{10'd0, 10'd255, 10'd100};
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      pulse_start(vin[i]);
      wait_complete(lat, bc);
      checks++;
      if (lat !== 11) begin errors++; $display("FAIL b2b_latency[%0d] got %0d want 11", i, lat); end
      checks++;
      if (binary_data !== vexp[i]) begin errors++; $display("FAIL b2b_result[%0d] got %0d want %0d", i, binary_data, vexp[i]); end
      @(negedge clk);
      checks++;
      if (conversion_complete !== 1'b0) begin errors++; $display("FAIL b2b_one_pulse[%0d] got %0b want 0", i, conversion_complete); end
    end
  endtask

  task automatic test_invalid();
    logic [11:0] vin [3] = '{12'h1A3, 12'hF00, 12'h00C};
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      pulse_start(vin[i]);
      wait_complete(lat, bc);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL inv_latency[%0d] got %0d want 1", i, lat); end
      checks++;
      if (bc !== 1) begin errors++; $display("FAIL inv_busy_cycles[%0d] got %0d want 1", i, bc); end
      checks++;
      if (digit_error !== 1'b1) begin errors++; $display("FAIL inv_digit_error[%0d] got %0b want 1", i, digit_error); end
      checks++;
      if (binary_data !== 10'd0) begin errors++; $display("FAIL inv_result[%0d] got %0d want 0", i, binary_data); end
      @(negedge clk);
      checks++;
      if (conversion_complete !== 1'b0 || busy !== 1'b0 || digit_error !== 1'b1) begin
        errors++;
        $display("FAIL inv_after[%0d] got complete=%0b busy=%0b err=%0b want 0 0 1",
                 i, conversion_complete, busy, digit_error);
      end
    end
  endtask

  task automatic test_ignore_restart();
    int lat, bc, extra;
    pulse_start(12'h042);
    checks++;
    if (digit_error !== 1'b0) begin errors++; $display("FAIL ign_err_cleared got %0b want 0", digit_error); end
    repeat (3) @(negedge clk);
    pulse_start(12'h777);
    bcd_data = 12'h888;
    wait_complete(lat, bc);
    checks++;
    if (lat !== 7) begin errors++; $display("FAIL ign_latency got %0d want 7", lat); end
    checks++;
    if (binary_data !== 10'd42) begin errors++; $display("FAIL ign_result got %0d want 42", binary_data); end
    extra = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (conversion_complete) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL ign_extra_pulses got %0d want 0", extra); end
    checks++;
    if (binary_data !== 10'd42) begin errors++; $display("FAIL ign_hold got %0d want 42", binary_data); end
  endtask

  task automatic test_reset_abort();
    int lat, bc, pulses;
    pulse_start(12'h500);
    repeat (3) @(negedge clk);
    reset  = 1'b1;
    pulses = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || conversion_complete !== 1'b0 || binary_data !== 10'd0 || digit_error !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs got busy=%0b complete=%0b bin=%0d err=%0b want all 0",
               busy, conversion_complete, binary_data, digit_error);
    end
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (conversion_complete) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL abort_pulses got %0d want 0", pulses); end
    pulse_start(12'h321);
    wait_complete(lat, bc);
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL abort_restart_latency got %0d want 11", lat); end
    checks++;
    if (binary_data !== 10'd321) begin errors++; $display("FAIL abort_restart_result got %0d want 321", binary_data); end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    int lat, bc;
    logic [11:0] v;
    logic [9:0]  expv;
    for (int i = 0; i < 1000; i++) begin
      v    = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
      expv = 10'(i);
      pulse_start(v);
      wait_complete(lat, bc);
      checks++;
      if (lat !== 11) begin errors++; $display("FAIL sweep_latency[%0d] got %0d want 11", i, lat); end
      checks++;
      if (binary_data !== expv || digit_error !== 1'b0) begin
        errors++;
        $display("FAIL sweep_result[%0d] got %0d err=%0b want %0d err=0", i, binary_data, digit_error, expv);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_999();
    test_back_to_back();
    test_invalid();
    test_ignore_restart();
    test_reset_abort();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
